muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two source operands read from the register file (rs, rt) and computes the MIPS MULT, MULTU, DIV and DIVU results. Results are held in the architectural HI/LO registers, which are also written directly by MTHI/MTLO. HI/LO are exposed to the writeback path for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit (op codes, FSM states, default width).
package muldiv_pkg;

  localparam int unsigned MULDIV_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    MULDIV_OP_MULT  = 3'd0,
    MULDIV_OP_MULTU = 3'd1,
    MULDIV_OP_DIV   = 3'd2,
    MULDIV_OP_DIVU  = 3'd3,
    MULDIV_OP_MTHI  = 3'd4,
    MULDIV_OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_negate,
  output logic [WIDTH-1:0] o_value
);

  always_comb begin
    o_value = i_value;
    if (i_negate) o_value = ~i_value + WIDTH'(1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV/DIVU only pulse done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam int unsigned AW = 2 * DATA_WIDTH;

  muldiv_state_e         r_state;
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_acc;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic                  r_neg_q;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_signed;
  logic                  w_neg_a;
  logic                  w_neg_b;
  logic                  w_is_iter;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [AW-1:0]         w_mul_next;
  logic [AW-1:0]         w_prod;

`ifdef MULDIV_DIV_EN
  logic                  r_is_div;
  logic                  r_neg_r;
  logic                  r_div0;
  logic                  w_is_div;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_qbit;
  logic [AW-1:0]         w_div_next;
  logic [DATA_WIDTH-1:0] w_quo;
  logic [DATA_WIDTH-1:0] w_rem;
`endif

  always_comb begin
    w_signed = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
    w_neg_a  = w_signed & operand_a[DATA_WIDTH-1];
    w_neg_b  = w_signed & operand_b[DATA_WIDTH-1];
`ifdef MULDIV_DIV_EN
    w_is_div  = (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    w_is_iter = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU) || w_is_div;
`else
    w_is_iter = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU);
`endif
  end

  muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_a (
    .i_value (operand_a),
    .i_negate(w_neg_a),
    .o_value (w_mag_a)
  );

  muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_b (
    .i_value (operand_b),
    .i_negate(w_neg_b),
    .o_value (w_mag_b)
  );

  muldiv_sign_fix #(.WIDTH(AW)) u_fix_prod (
    .i_value (r_acc),
    .i_negate(r_neg_q),
    .o_value (w_prod)
  );

  // Shift-add: the partial product's upper half absorbs the multiplicand, then the whole pair shifts right.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[AW-1:DATA_WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Restoring divide: remainder lives in the upper half, quotient bits shift into the lower half.
  always_comb begin
    w_rem_sh   = {r_acc[AW-1:DATA_WIDTH], r_a[DATA_WIDTH-1]};
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_qbit     = ~w_diff[DATA_WIDTH];
    w_div_next = {(w_qbit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0]),
                  r_acc[DATA_WIDTH-2:0], w_qbit};
  end

  muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_quo (
    .i_value (r_acc[DATA_WIDTH-1:0]),
    .i_negate(r_neg_q),
    .o_value (w_quo)
  );

  muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_rem (
    .i_value (r_acc[AW-1:DATA_WIDTH]),
    .i_negate(r_neg_r),
    .o_value (w_rem)
  );
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && w_is_iter) begin
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
`ifdef MULDIV_DIV_EN
            r_is_div <= w_is_div;
            r_neg_r  <= w_neg_a;
            r_div0   <= (operand_b == '0);
`endif
          end else if (start) begin
            case (op)
              MULDIV_OP_MTHI: begin
                r_hi   <= operand_a;
                r_done <= 1'b1;
              end
              MULDIV_OP_MTLO: begin
                r_lo   <= operand_a;
                r_done <= 1'b1;
              end
              MULDIV_OP_DIV, MULDIV_OP_DIVU: r_done <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            r_acc <= w_div_next;
            r_a   <= r_a << 1;
          end else begin
            r_acc <= w_mul_next;
            r_b   <= r_b >> 1;
          end
`else
          r_acc <= w_mul_next;
          r_b   <= r_b >> 1;
`endif
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DATA_WIDTH - 1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            r_lo <= r_div0 ? '1 : w_quo;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[AW-1:DATA_WIDTH];
            r_lo <= w_prod[DATA_WIDTH-1:0];
          end
`else
          r_hi <= w_prod[AW-1:DATA_WIDTH];
          r_lo <= w_prod[DATA_WIDTH-1:0];
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, negedge monitor pops and compares.
module tb_muldiv_unit;

  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic          busy;
  logic          done;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  muldiv_unit #(.DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_busy_first = 0;
  int          m_busy_last  = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural results from plain arithmetic; k is the cycle index of the sampling edge.
  task automatic model_issue(input int k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 ia, ib;
    logic [31:0]        nh, nl;
    exp_t               e;
    if (k - 1 <= m_busy_last) return;
    nh = m_hi;
    nl = m_lo;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        nh = sp[63:32];
        nl = sp[31:0];
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        nh = up[63:32];
        nl = up[31:0];
      end
      3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          nl = 32'hFFFF_FFFF;
          nh = a;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          nl = 32'h8000_0000;
          nh = 32'd0;
        end else if (o == 3'd2) begin
          ia = a;
          ib = b;
          nl = ia / ib;
          nh = ia % ib;
        end else begin
          nl = a / b;
          nh = a % b;
        end
`else
        e.cyc = k; e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        return;
`endif
      end
      3'd4: begin
        m_hi = a;
        e.cyc = k; e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        return;
      end
      3'd5: begin
        m_lo = a;
        e.cyc = k; e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        return;
      end
      default: return;
    endcase
    m_busy_first = k;
    m_busy_last  = k + 32;
    m_hi = nh;
    m_lo = nl;
    e.cyc = k + 33; e.hi = nh; e.lo = nl;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    model_issue(cyc, o, a, b);
    start     = 1'b0;
    op        = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_free();
    for (int i = 0; i < 100 && cyc <= m_busy_last; i++) idle(1);
    check("wait_free_timeout", 64'(cyc <= m_busy_last), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clock) begin
    check("busy", 64'(busy), 64'(cyc >= m_busy_first && cyc <= m_busy_last));
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check("missing_done", 64'(done), 64'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    op        = 3'd0;
    operand_a = '0;
    operand_b = '0;
    idle(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    resetn = 1'b1;
    idle(1);

    drive(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_free();
    drive(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_free();
    drive(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_free();
    drive(3'd3, 32'd100, 32'd7);
    wait_free();
    drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_free();
    drive(3'd3, 32'h0000_1234, 32'd0);
    wait_free();

    drive(3'd4, 32'hCAFE_BABE, 32'd0);
    drive(3'd5, 32'h1234_5678, 32'd0);
    idle(2);

    drive(3'd0, 32'h0001_2345, 32'hFFFF_FF00);
    idle(9);
    drive(3'd0, 32'h7777_7777, 32'h3333_3333);
    wait_free();
    drive(3'd1, 32'hDEAD_BEEF, 32'h0000_0003);
    idle(2);

    drive(3'd2, 32'h0000_4000, 32'd3);
    idle(14);
    #1;
    resetn = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    m_busy_last = -1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    idle(2);
    resetn = 1'b1;
    idle(1);
    drive(3'd1, 32'h0001_0001, 32'hFFFF_0000);
    wait_free();

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 4) != 0) wait_free();
      drive(3'($urandom_range(0, 7)), pick(), pick());
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
    check("drain", 64'(sb.size()), 64'd0);
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
